// File: rtl/sub_div_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sub_div_ctrl_pkg
// Shared types and constants for the 4-bit restoring divider controller.
//   WIDTH   : operand / result width
//   STEPS   : number of restoring steps per division (one per quotient bit)
//   state_e : controller states IDLE, CALC, DONE
//   step_t  : 3-bit step counter type
// -----------------------------------------------------------------------------
package sub_div_ctrl_pkg;

  localparam int WIDTH = 4;
  localparam int STEPS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef logic [2:0] step_t;

endpackage

// File: rtl/sub_div_step.sv
// -----------------------------------------------------------------------------
// sub_div_step
// Combinational single restoring-division step (MSB-first).
// Ports:
//   r_i            [4:0] current partial remainder R
//   dividend_bit_i       next dividend bit shifted into R
//   divisor_i      [3:0] divisor
//   r_next_o       [4:0] partial remainder after this step
//   q_bit_o              quotient bit produced by this step
// -----------------------------------------------------------------------------
module sub_div_step
  import sub_div_ctrl_pkg::*;
(
  input  logic [WIDTH:0]   r_i,
  input  logic             dividend_bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   r_next_o,
  output logic             q_bit_o
);

  logic [WIDTH:0]   r_shift_s;
  logic [WIDTH+1:0] diff_s;

  // Shifted remainder R' = {R[3:0], bit}.
  assign r_shift_s = {r_i[WIDTH-1:0], dividend_bit_i};

  // The subtraction uses the full {R, bit} so the MSB of diff_s acts as the
  // borrow. Because R < divisor always holds on entry, R[4] is zero and the
  // low five bits equal R' - divisor.
  assign diff_s   = {r_i, dividend_bit_i} - {2'b00, divisor_i};
  assign q_bit_o  = ~diff_s[WIDTH+1];
  assign r_next_o = q_bit_o ? diff_s[WIDTH:0] : r_shift_s;

endmodule

// File: rtl/sub_div_ctrl.sv
// -----------------------------------------------------------------------------
// sub_div_ctrl
// 4-bit unsigned restoring divider: IDLE -> CALC (4 steps) -> DONE -> IDLE.
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   start            begin a division (sampled only in IDLE)
//   dividend,divisor operands, captured on the accepted start edge
//   quotient         result, held until the next DONE entry
//   remainder        result, held until the next DONE entry
//   busy             high while in CALC
//   done             one-cycle pulse while in DONE
//   div_err          divide-by-zero flag, valid while done is high
// Configuration macro SUB_DIV_CTRL_ZERO_DETECT_EN: when defined, a zero divisor
// skips CALC and goes straight to DONE with div_err=1. When undefined, a zero
// divisor runs the normal four steps and div_err is tied low.
// -----------------------------------------------------------------------------
module sub_div_ctrl
  import sub_div_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_err
);

  state_e           state_q, state_d;
  step_t            step_q, step_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] a_q, a_d;       // dividend, shifted left one bit per step
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] qsr_q, qsr_d;   // quotient shift register
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             busy_q, done_q;
`ifdef SUB_DIV_CTRL_ZERO_DETECT_EN
  logic             err_q, err_d;
`endif

  logic [WIDTH:0]   r_next_s;
  logic             q_bit_s;

  // The single step unit is shared by every CALC cycle; the current dividend
  // bit is always the MSB of the shifting operand register.
  sub_div_step u_step (
    .r_i            (r_q),
    .dividend_bit_i (a_q[WIDTH-1]),
    .divisor_i      (b_q),
    .r_next_o       (r_next_s),
    .q_bit_o        (q_bit_s)
  );

  // Next-state and datapath update logic.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    r_d     = r_q;
    a_d     = a_q;
    b_d     = b_q;
    qsr_d   = qsr_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
`ifdef SUB_DIV_CTRL_ZERO_DETECT_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d    = dividend;
          b_d    = divisor;
          r_d    = '0;
          qsr_d  = '0;
          step_d = 3'd0;
`ifdef SUB_DIV_CTRL_ZERO_DETECT_EN
          if (divisor == 4'd0) begin
            state_d = DONE;
            quot_d  = 4'hF;
            rem_d   = dividend;
            err_d   = 1'b1;
          end else begin
            state_d = CALC;
          end
`else
          state_d = CALC;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        r_d    = r_next_s;
        a_d    = {a_q[WIDTH-2:0], 1'b0};
        qsr_d  = {qsr_q[WIDTH-2:0], q_bit_s};
        step_d = step_q + 3'd1;
        if (step_q == step_t'(STEPS - 1)) begin
          // Last step: results become visible on the DONE-entry edge.
          state_d = DONE;
          quot_d  = {qsr_q[WIDTH-2:0], q_bit_s};
          rem_d   = r_next_s[WIDTH-1:0];
`ifdef SUB_DIV_CTRL_ZERO_DETECT_EN
          err_d   = 1'b0;
`endif
        end else begin
          state_d = CALC;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= 3'd0;
      r_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      qsr_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SUB_DIV_CTRL_ZERO_DETECT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      r_q     <= r_d;
      a_q     <= a_d;
      b_q     <= b_d;
      qsr_q   <= qsr_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      busy_q  <= (state_d == CALC);
      done_q  <= (state_d == DONE);
`ifdef SUB_DIV_CTRL_ZERO_DETECT_EN
      err_q   <= err_d;
`endif
    end
  end

  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef SUB_DIV_CTRL_ZERO_DETECT_EN
  assign div_err   = err_q;
`else
  assign div_err   = 1'b0;
`endif

endmodule

// File: tb/tb_sub_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sub_div_ctrl
// Self-checking bench for sub_div_ctrl. Expected results come from plain
// integer division / modulo, with the zero-divisor behaviour chosen by
// SUB_DIV_CTRL_ZERO_DETECT_EN.
// -----------------------------------------------------------------------------
module tb_sub_div_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       busy;
  logic       done;
  logic       div_err;

  int pass_cnt = 0;
  int total_cnt = 0;

  sub_div_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .div_err   (div_err)
  );

  always #5 clk = ~clk;

  // Reference: arithmetic result, error flag and number of cycles from the
  // start edge to the cycle in which done is seen (0 = cycle after edge k).
  task automatic ref_div(input int a, input int b, output int q, output int r,
                         output int e, output int lat);
    if (b == 0) begin
      q = 15;
      r = a;
`ifdef SUB_DIV_CTRL_ZERO_DETECT_EN
      e = 1; lat = 0;
`else
      e = 0; lat = 4;
`endif
    end else begin
      q = a / b; r = a % b; e = 0; lat = 4;
    end
  endtask

  // Issue one start, scramble the operands afterwards, and observe the result.
  task automatic run_div(input logic [3:0] a, input logic [3:0] b,
                         output int lat, output logic busy_ok,
                         output logic [3:0] q, output logic [3:0] r,
                         output logic e, output logic done_after);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    dividend = 4'($urandom); divisor = 4'($urandom);
    lat = -1; busy_ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (done) begin
        lat = i;
        if (busy !== 1'b0) busy_ok = 1'b0;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
    end
    q = quotient; r = remainder; e = div_err;
    @(posedge clk); #1;
    done_after = done;
  endtask

  // Run one division and compare everything against the reference.
  task automatic check_div(input string tag, input logic [3:0] a, input logic [3:0] b);
    int lat, elat, eq, er, ee;
    logic bok, e, da;
    logic [3:0] q, r;
    ref_div(int'(a), int'(b), eq, er, ee, elat);
    run_div(a, b, lat, bok, q, r, e, da);
    total_cnt++;
    if (lat !== elat || bok !== 1'b1 || da !== 1'b0) begin
      $display("FAIL %s %0d/%0d timing: lat=%0d busy_ok=%0b done_after=%0b, want lat=%0d busy_ok=1 done_after=0",
               tag, a, b, lat, bok, da, elat);
    end else pass_cnt++;
    total_cnt++;
    if (q !== 4'(eq) || r !== 4'(er) || e !== 1'(ee)) begin
      $display("FAIL %s %0d/%0d result: q=%0d r=%0d err=%0b, want q=%0d r=%0d err=%0d",
               tag, a, b, q, r, e, eq, er, ee);
    end else pass_cnt++;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; dividend = 4'd13; divisor = 4'd3;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if ({quotient, remainder, busy, done, div_err} !== 11'd0) begin
      $display("FAIL reset: q=%0d r=%0d busy=%0b done=%0b err=%0b, want all 0",
               quotient, remainder, busy, done, div_err);
    end else pass_cnt++;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
  endtask

  task automatic test_directed;
    check_div("directed", 4'd13, 4'd3);
    check_div("directed", 4'd15, 4'd1);
    check_div("directed", 4'd2, 4'd7);
    check_div("directed", 4'd15, 4'd15);
    check_div("directed", 4'd0, 4'd9);
  endtask

  task automatic test_zero_div;
    check_div("zero_div", 4'd7, 4'd0);
    check_div("zero_div", 4'd0, 4'd0);
  endtask

  task automatic test_ignore_start;
    int idx;
    logic quiet;
    @(negedge clk);
    start = 1'b1; dividend = 4'd13; divisor = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; dividend = 4'd9; divisor = 4'd2;
    @(posedge clk); #1;
    start = 1'b0;
    idx = 1;
    while (!done && idx < 12) begin
      @(posedge clk); #1;
      idx++;
    end
    total_cnt++;
    if (idx !== 4 || quotient !== 4'd4 || remainder !== 4'd1) begin
      $display("FAIL ignore_start: done_at=%0d q=%0d r=%0d, want done_at=4 q=4 r=1",
               idx, quotient, remainder);
    end else pass_cnt++;
    quiet = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || done !== 1'b0) quiet = 1'b0;
    end
    total_cnt++;
    if (quiet !== 1'b1) begin
      $display("FAIL ignore_start_quiet: busy/done activity after result, want none");
    end else pass_cnt++;
    check_div("after_ignore", 4'd9, 4'd2);
  endtask

  task automatic test_reset_abort;
    logic no_done;
    @(negedge clk);
    start = 1'b1; dividend = 4'd13; divisor = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if ({quotient, remainder, busy, done, div_err} !== 11'd0) begin
      $display("FAIL reset_abort: q=%0d r=%0d busy=%0b done=%0b err=%0b, want all 0",
               quotient, remainder, busy, done, div_err);
    end else pass_cnt++;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    no_done = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) no_done = 1'b0;
    end
    total_cnt++;
    if (no_done !== 1'b1) begin
      $display("FAIL reset_abort_quiet: done/busy seen after abort, want none");
    end else pass_cnt++;
    check_div("after_abort", 4'd12, 4'd5);
  endtask

  task automatic test_sweep;
    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        check_div("sweep", 4'(a), 4'(b));
      end
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 40; n++) begin
      check_div("random", 4'($urandom), 4'($urandom_range(0, 15)));
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] a, b;
    for (int n = 0; n < 6; n++) begin
      a = 4'($urandom); b = 4'($urandom_range(1, 15));
      check_div("back_to_back", a, b);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; dividend = 4'd0; divisor = 4'd0;
    test_reset;
    test_directed;
    test_zero_div;
    test_ignore_start;
    test_reset_abort;
    test_back_to_back;
    test_sweep;
    test_random;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
